// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the zero-latency data memory.
// Performs alignment checks and returns load data or errors one cycle after the grant.
module dmem_arbiter #(
    parameter int MAX_BURST = 4,
    parameter bit PRIO_RST  = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [1:0]  p0_size,
    input  logic        p0_sign,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [1:0]  p1_size,
    input  logic        p1_sign,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,

    output logic        mem_write,
    output logic        mem_sign,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [1:0] SIZE_NONE = 2'b11;

    typedef enum logic {
        PRIO_P0 = 1'b0,
        PRIO_P1 = 1'b1
    } prio_e;

    localparam prio_e PRIO_INIT = PRIO_RST ? PRIO_P1 : PRIO_P0;

    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            2'b00:   return (lsb != 2'b00);
            2'b01:   return lsb[0];
            2'b10:   return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    prio_e            ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        p0_rvalid_q, p1_rvalid_q;
    logic        p0_err_q, p1_err_q;
    logic [31:0] p0_rdata_q, p1_rdata_q;

    logic        contested;
    logic        gnt_any;
    logic        sel_p1;
    logic        g_we;
    logic        g_sign;
    logic [1:0]  g_size;
    logic [31:0] g_addr;
    logic [31:0] g_wdata;
    logic        g_illegal;
    logic        g_load_ok;

    // Grant selection and memory-port mux; rst_n gates every grant combinationally
    always_comb begin
        contested = p0_req & p1_req;
        gnt_any   = rst_n & (p0_req | p1_req);
        sel_p1    = contested ? (ptr_q == PRIO_P1) : ~p0_req;

        p0_gnt = gnt_any & ~sel_p1;
        p1_gnt = gnt_any & sel_p1;

        g_we    = 1'b0;
        g_sign  = 1'b0;
        g_size  = SIZE_NONE;
        g_addr  = '0;
        g_wdata = '0;
        if (p0_gnt) begin
            g_we    = p0_we;
            g_sign  = p0_sign;
            g_size  = p0_size;
            g_addr  = p0_addr;
            g_wdata = p0_wdata;
        end else if (p1_gnt) begin
            g_we    = p1_we;
            g_sign  = p1_sign;
            g_size  = p1_size;
            g_addr  = p1_addr;
            g_wdata = p1_wdata;
        end

        g_illegal = gnt_any & is_illegal(g_size, g_addr[1:0]);
        g_load_ok = gnt_any & ~g_we & ~g_illegal;

        mem_write = gnt_any & g_we & ~g_illegal;
        mem_size  = (gnt_any & ~g_illegal) ? g_size : SIZE_NONE;
        mem_sign  = g_sign;
        mem_addr  = g_addr;
        mem_wdata = g_wdata;
    end

    // Burst counter only advances while both ports compete
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = '0;
        if (gnt_any && contested) begin
            if (cnt_q == CNT_LAST) begin
                ptr_d = (ptr_q == PRIO_P0) ? PRIO_P1 : PRIO_P0;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PRIO_INIT;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_rvalid_q <= 1'b0;
            p0_err_q    <= 1'b0;
            p0_rdata_q  <= '0;
        end else begin
            p0_rvalid_q <= p0_gnt & g_load_ok;
            p0_err_q    <= p0_gnt & g_illegal;
            if (p0_gnt && g_load_ok) begin
                p0_rdata_q <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_rvalid_q <= 1'b0;
            p1_err_q    <= 1'b0;
            p1_rdata_q  <= '0;
        end else begin
            p1_rvalid_q <= p1_gnt & g_load_ok;
            p1_err_q    <= p1_gnt & g_illegal;
            if (p1_gnt && g_load_ok) begin
                p1_rdata_q <= mem_rdata;
            end
        end
    end

    assign p0_rvalid = p0_rvalid_q;
    assign p0_err    = p0_err_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p1_err    = p1_err_q;
    assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed memory model attached
// to the shared port (combinational read with extension, posedge write).
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        p0_req = 0, p0_we = 0, p0_sign = 0;
    logic [1:0]  p0_size = 0;
    logic [31:0] p0_addr = 0, p0_wdata = 0;
    logic        p0_gnt, p0_rvalid, p0_err;
    logic [31:0] p0_rdata;

    logic        p1_req = 0, p1_we = 0, p1_sign = 0;
    logic [1:0]  p1_size = 0;
    logic [31:0] p1_addr = 0, p1_wdata = 0;
    logic        p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p1_rdata;

    logic        mem_write, mem_sign;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [7:0]  mem [0:131071];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_BURST(4), .PRIO_RST(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_sign(p0_sign),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt),
        .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_sign(p1_sign),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_gnt(p1_gnt),
        .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_write(mem_write), .mem_sign(mem_sign), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        logic [16:0] b;
        b = a[16:0];
        case (sz)
            2'b00:   return {mem[b + 17'd3], mem[b + 17'd2], mem[b + 17'd1], mem[b]};
            2'b01:   return {{16{sg & mem[b + 17'd1][7]}}, mem[b + 17'd1], mem[b]};
            2'b10:   return {{24{sg & mem[b][7]}}, mem[b]};
            default: return 32'h0;
        endcase
    endfunction

    assign mem_rdata = mem_rd(mem_addr, mem_size, mem_sign);

    always @(posedge clk) begin
        if (mem_write) begin
            case (mem_size)
                2'b00: begin
                    mem[mem_addr[16:0]]          <= mem_wdata[7:0];
                    mem[mem_addr[16:0] + 17'd1]  <= mem_wdata[15:8];
                    mem[mem_addr[16:0] + 17'd2]  <= mem_wdata[23:16];
                    mem[mem_addr[16:0] + 17'd3]  <= mem_wdata[31:24];
                end
                2'b01: begin
                    mem[mem_addr[16:0]]          <= mem_wdata[7:0];
                    mem[mem_addr[16:0] + 17'd1]  <= mem_wdata[15:8];
                end
                2'b10: mem[mem_addr[16:0]] <= mem_wdata[7:0];
                default: ;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic req, input logic we, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a, input logic [31:0] wd);
        p0_req = req; p0_we = we; p0_size = sz; p0_sign = sg; p0_addr = a; p0_wdata = wd;
    endtask

    task automatic drive1(input logic req, input logic we, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a, input logic [31:0] wd);
        p1_req = req; p1_we = we; p1_size = sz; p1_sign = sg; p1_addr = a; p1_wdata = wd;
    endtask

    logic [9:0] burst_pat;
    logic       exp_sel, prev_sel;

    initial begin
        for (int i = 0; i < 131072; i++) mem[i] = 8'h00;

        // Reset state
        p0_req = 1'b1;
        #2;
        chk("rst_gnt0", {31'b0, p0_gnt}, 32'd0);
        chk("rst_mem_size", {30'b0, mem_size}, 32'd3);
        chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
        p0_req = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("idle_rvalid0", {31'b0, p0_rvalid}, 32'd0);
        chk("idle_rdata1", p1_rdata, 32'd0);
        chk("idle_mem_size", {30'b0, mem_size}, 32'd3);

        // 1: p0 store word then load word at 0x100
        drive0(1, 1, 2'b00, 0, 32'h100, 32'hDEADBEEF);
        #1;
        chk("t1_sw_gnt0", {31'b0, p0_gnt}, 32'd1);
        chk("t1_sw_gnt1", {31'b0, p1_gnt}, 32'd0);
        chk("t1_sw_mem_write", {31'b0, mem_write}, 32'd1);
        tick();
        drive0(1, 0, 2'b00, 0, 32'h100, 32'h0);
        #1;
        chk("t1_lw_gnt0", {31'b0, p0_gnt}, 32'd1);
        chk("t1_lw_rvalid_after_sw", {31'b0, p0_rvalid}, 32'd0);
        tick();
        drive0(0, 0, 2'b00, 0, 32'h0, 32'h0);
        chk("t1_rvalid0", {31'b0, p0_rvalid}, 32'd1);
        chk("t1_rdata0", p0_rdata, 32'hDEADBEEF);
        chk("t1_rvalid1", {31'b0, p1_rvalid}, 32'd0);
        chk("t1_rdata1", p1_rdata, 32'd0);
        tick();
        chk("t1_rvalid0_pulse", {31'b0, p0_rvalid}, 32'd0);
        chk("t1_rdata0_hold", p0_rdata, 32'hDEADBEEF);

        // 3: p1 store byte 0x80 @0x23, then lb and lbu back to back
        drive1(1, 1, 2'b10, 0, 32'h23, 32'h00000080);
        #1;
        chk("t3_sb_gnt1", {31'b0, p1_gnt}, 32'd1);
        tick();
        drive1(1, 0, 2'b10, 1, 32'h23, 32'h0);
        tick();
        chk("t3_lb_rvalid1", {31'b0, p1_rvalid}, 32'd1);
        chk("t3_lb_rdata1", p1_rdata, 32'hFFFFFF80);
        drive1(1, 0, 2'b10, 0, 32'h23, 32'h0);
        tick();
        drive1(0, 0, 2'b00, 0, 32'h0, 32'h0);
        chk("t3_lbu_rvalid1", {31'b0, p1_rvalid}, 32'd1);
        chk("t3_lbu_rdata1", p1_rdata, 32'h00000080);
        chk("t3_rdata0_kept", p0_rdata, 32'hDEADBEEF);

        // 4: misaligned sw from p0 and lh from p1, contested
        drive0(1, 1, 2'b00, 0, 32'h102, 32'h12345678);
        drive1(1, 0, 2'b01, 1, 32'h31, 32'h0);
        #1;
        chk("t4_gnt0", {31'b0, p0_gnt}, 32'd1);
        chk("t4_gnt1_wait", {31'b0, p1_gnt}, 32'd0);
        chk("t4_mem_write", {31'b0, mem_write}, 32'd0);
        chk("t4_mem_size0", {30'b0, mem_size}, 32'd3);
        tick();
        drive0(0, 0, 2'b00, 0, 32'h0, 32'h0);
        #1;
        chk("t4_gnt1", {31'b0, p1_gnt}, 32'd1);
        chk("t4_mem_size1", {30'b0, mem_size}, 32'd3);
        chk("t4_err0", {31'b0, p0_err}, 32'd1);
        chk("t4_rvalid0", {31'b0, p0_rvalid}, 32'd0);
        tick();
        drive1(0, 0, 2'b00, 0, 32'h0, 32'h0);
        chk("t4_err1", {31'b0, p1_err}, 32'd1);
        chk("t4_err0_pulse", {31'b0, p0_err}, 32'd0);
        chk("t4_rvalid1", {31'b0, p1_rvalid}, 32'd0);
        chk("t4_rdata1_kept", p1_rdata, 32'h00000080);
        drive0(1, 0, 2'b00, 0, 32'h100, 32'h0);
        tick();
        drive0(0, 0, 2'b00, 0, 32'h0, 32'h0);
        chk("t4_mem_unchanged", p0_rdata, 32'hDEADBEEF);

        // 5: reset asserted in the third cycle of a p0 store burst
        drive0(1, 1, 2'b00, 0, 32'h200, 32'h11223344);
        drive1(1, 0, 2'b00, 0, 32'h100, 32'h0);
        #1;
        chk("t5_c1_gnt0", {31'b0, p0_gnt}, 32'd1);
        chk("t5_c1_write", {31'b0, mem_write}, 32'd1);
        tick();
        drive0(1, 1, 2'b00, 0, 32'h206, 32'hAAAAAAAA);
        #1;
        chk("t5_c2_gnt0", {31'b0, p0_gnt}, 32'd1);
        tick();
        chk("t5_c3_err0", {31'b0, p0_err}, 32'd1);
        drive0(1, 1, 2'b00, 0, 32'h208, 32'h55667788);
        #1;
        chk("t5_c3_gnt0", {31'b0, p0_gnt}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_gnt0", {31'b0, p0_gnt}, 32'd0);
        chk("t5_rst_gnt1", {31'b0, p1_gnt}, 32'd0);
        chk("t5_rst_write", {31'b0, mem_write}, 32'd0);
        chk("t5_rst_size", {30'b0, mem_size}, 32'd3);
        chk("t5_rst_err0", {31'b0, p0_err}, 32'd0);
        chk("t5_rst_rdata0", p0_rdata, 32'd0);
        chk("t5_rst_rdata1", p1_rdata, 32'd0);
        tick();
        chk("t5_store_absent", {mem[17'h20B], mem[17'h20A], mem[17'h209], mem[17'h208]}, 32'd0);
        chk("t5_store_c1", {mem[17'h203], mem[17'h202], mem[17'h201], mem[17'h200]}, 32'h11223344);
        rst_n = 1'b1;
        drive0(1, 0, 2'b00, 0, 32'h200, 32'h0);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("t5_post_gnt0_c%0d", c), {31'b0, p0_gnt}, (c < 4) ? 32'd1 : 32'd0);
            chk($sformatf("t5_post_gnt1_c%0d", c), {31'b0, p1_gnt}, (c < 4) ? 32'd0 : 32'd1);
            tick();
        end
        drive0(0, 0, 2'b00, 0, 32'h0, 32'h0);
        drive1(0, 0, 2'b00, 0, 32'h0, 32'h0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // 6: p1 alone then p0 alone, each granted at once
        drive1(1, 0, 2'b00, 0, 32'h100, 32'h0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("t6_p1_alone_c%0d", c), {31'b0, p1_gnt}, 32'd1);
            tick();
        end
        drive1(0, 0, 2'b00, 0, 32'h0, 32'h0);
        drive0(1, 0, 2'b00, 0, 32'h100, 32'h0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("t6_p0_alone_c%0d", c), {31'b0, p0_gnt}, 32'd1);
            tick();
        end

        // 2: both ports load every cycle; bursts of four alternate
        burst_pat = 10'b0011110000;
        drive1(1, 0, 2'b00, 0, 32'h100, 32'h0);
        prev_sel = 1'b0;
        for (int c = 0; c < 10; c++) begin
            exp_sel = burst_pat[c];
            #1;
            chk($sformatf("t2_gnt0_c%0d", c), {31'b0, p0_gnt}, {31'b0, ~exp_sel});
            chk($sformatf("t2_gnt1_c%0d", c), {31'b0, p1_gnt}, {31'b0, exp_sel});
            tick();
            chk($sformatf("t2_rvalid0_c%0d", c), {31'b0, p0_rvalid}, {31'b0, ~exp_sel});
            chk($sformatf("t2_rvalid1_c%0d", c), {31'b0, p1_rvalid}, {31'b0, exp_sel});
            prev_sel = exp_sel;
        end
        drive0(0, 0, 2'b00, 0, 32'h0, 32'h0);
        drive1(0, 0, 2'b00, 0, 32'h0, 32'h0);
        chk("t2_rdata1", p1_rdata, 32'hDEADBEEF);
        tick();
        chk("t2_idle_rvalid1", {31'b0, p1_rvalid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
